// File: rtl/cpu_reg_pkg.sv
// cpu_reg_pkg: shared constants and helpers for the register decode/scoreboard logic.
package cpu_reg_pkg;
    localparam int DEF_NUM_REGS = 16;
    localparam logic [6:0] SRC_SEL_IMM = 7'd0;

    function automatic logic [63:0] onehot_dec(input logic [5:0] idx);
        return 64'(1) << idx;
    endfunction

    // Select 0 is reserved for the immediate, so register i maps to i+1.
    function automatic logic [6:0] idx_to_sel(input logic imm, input logic [5:0] idx);
        return imm ? SRC_SEL_IMM : {1'b0, idx} + 7'd1;
    endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write vector, outstanding count, RAW/WAW/full stall and writeback error flag.
module reg_scoreboard
    import cpu_reg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int MAX_PEND = 4,
    parameter int BYPASS   = 0,
    parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] rsrc_addr,
    input  logic [ADDR_W-1:0] rdst_addr,
    input  logic              src_imm,
    input  logic              wr_req,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              dec_ready,
    output logic              wb_hit,
    output logic [CNT_W-1:0]  pend_cnt,
    output logic              wb_err
);
    logic [NUM_REGS-1:0] pend_q, pend_d, pend_eff, clr_vec, set_vec;
    logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d, cnt_eff;
    logic                wb_err_q, wb_err_d;
    logic                byp, raw, waw, full, set_en;

    always_comb begin
        wb_hit     = wb_valid && pend_q[wb_addr];
        clr_vec    = wb_hit ? NUM_REGS'(onehot_dec(6'(wb_addr))) : '0;
        // With bypass, a retiring writeback is treated as already gone for the stall decision.
        byp        = (BYPASS != 0) && wb_hit;
        pend_eff   = byp ? (pend_q & ~clr_vec) : pend_q;
        cnt_eff    = pend_cnt_q - CNT_W'(byp);
        raw        = !src_imm && pend_eff[rsrc_addr];
        waw        = wr_req && pend_eff[rdst_addr];
        full       = wr_req && (cnt_eff == CNT_W'(MAX_PEND));
        dec_ready  = !(raw || waw || full);
        set_en     = dec_valid && dec_ready && wr_req;
        set_vec    = set_en ? NUM_REGS'(onehot_dec(6'(rdst_addr))) : '0;
        pend_d     = (pend_q & ~clr_vec) | set_vec;
        pend_cnt_d = pend_cnt_q + CNT_W'(set_en) - CNT_W'(wb_hit);
        wb_err_d   = wb_err_q || (wb_valid && !pend_q[wb_addr]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign pend_cnt = pend_cnt_q;
    assign wb_err   = wb_err_q;
endmodule

// File: rtl/reg_decode_ctrl.sv
// reg_decode_ctrl: register address decoder with write scoreboard; registers issue fields and the one-hot write enable.
module reg_decode_ctrl
    import cpu_reg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int MAX_PEND = 4,
    parameter int BYPASS   = 0,
    parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [ADDR_W-1:0]   rsrc_addr,
    input  logic [ADDR_W-1:0]   rdst_addr,
    input  logic                src_imm,
    input  logic                wr_req,
    output logic                iss_valid,
    output logic [ADDR_W:0]     iss_src_sel,
    output logic [ADDR_W-1:0]   iss_dst_idx,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic [NUM_REGS-1:0] dst_we,
    output logic [CNT_W-1:0]    pend_cnt,
    output logic                wb_err
);
    localparam int SEL_W = ADDR_W + 1;

    logic                iss_valid_q, iss_valid_d;
    logic [ADDR_W:0]     iss_src_sel_q, iss_src_sel_d;
    logic [ADDR_W-1:0]   iss_dst_idx_q, iss_dst_idx_d;
    logic [NUM_REGS-1:0] dst_we_q, dst_we_d;
    logic                accept, wb_hit;

    reg_scoreboard #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .MAX_PEND(MAX_PEND),
        .BYPASS  (BYPASS),
        .CNT_W   (CNT_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .dec_valid(dec_valid),
        .rsrc_addr(rsrc_addr),
        .rdst_addr(rdst_addr),
        .src_imm  (src_imm),
        .wr_req   (wr_req),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .dec_ready(dec_ready),
        .wb_hit   (wb_hit),
        .pend_cnt (pend_cnt),
        .wb_err   (wb_err)
    );

    always_comb begin
        accept        = dec_valid && dec_ready;
        iss_valid_d   = accept;
        iss_src_sel_d = accept ? SEL_W'(idx_to_sel(src_imm, 6'(rsrc_addr))) : iss_src_sel_q;
        iss_dst_idx_d = accept ? rdst_addr : iss_dst_idx_q;
        dst_we_d      = wb_hit ? NUM_REGS'(onehot_dec(6'(wb_addr))) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_valid_q   <= 1'b0;
            iss_src_sel_q <= '0;
            iss_dst_idx_q <= '0;
            dst_we_q      <= '0;
        end else begin
            iss_valid_q   <= iss_valid_d;
            iss_src_sel_q <= iss_src_sel_d;
            iss_dst_idx_q <= iss_dst_idx_d;
            dst_we_q      <= dst_we_d;
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_src_sel = iss_src_sel_q;
    assign iss_dst_idx = iss_dst_idx_q;
    assign dst_we      = dst_we_q;
endmodule

// File: doc/reg_decode_ctrl.md
Name: reg_decode_ctrl

Overview:
Parametrised register-file address decoder with a write scoreboard, one generation on from the combinational 4-bit source/destination translator.
- Accepts source and destination register addresses from instruction decode under a valid/ready handshake.
- Produces a registered source mux select, with 0 reserved for immediate and i+1 for register i.
- Tracks outstanding destination writes, stalls decode on RAW/WAW hazards, and issues the one-hot register write enable when writeback retires.
- Sits between the instruction decoder and the register file / ALU operand mux.

Parameters:
- NUM_REGS, 16, number of architectural registers (power of two, 2..64).
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override).
- MAX_PEND, 4, maximum outstanding writes (1..NUM_REGS).
- BYPASS, 0, if 1 a same-cycle writeback clears the hazard for the incoming request.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode request valid.
- dec_ready  out  1  request accepted this cycle when dec_valid && dec_ready.
- rsrc_addr  in  ADDR_W  source register index.
- rdst_addr  in  ADDR_W  destination register index.
- src_imm  in  1  source is immediate; rsrc_addr is ignored.
- wr_req  in  1  instruction writes rdst_addr.
- iss_valid  out  1  one-cycle pulse, issued request.
- iss_src_sel  out  ADDR_W+1  0 means immediate, otherwise register index + 1.
- iss_dst_idx  out  ADDR_W  registered rdst_addr.
- wb_valid  in  1  writeback retiring.
- wb_addr  in  ADDR_W  writeback destination.
- dst_we  out  NUM_REGS  one-hot register write enable, one-cycle pulse.
- pend_cnt  out  $clog2(MAX_PEND+1)  outstanding write count.
- wb_err  out  1  sticky flag: writeback to a non-pending register.

Behaviour:
- Reset:
  - iss_valid=0, iss_src_sel=0, iss_dst_idx=0, dst_we=0, pend_cnt=0, wb_err=0.
  - Pending vector cleared.
  - Reset mid-operation discards all outstanding writes; no dst_we follows.
- Hazard (combinational, from current pending vector P):
  - raw = !src_imm && P[rsrc_addr].
  - waw = wr_req && P[rdst_addr].
  - full = wr_req && pend_cnt==MAX_PEND.
  - dec_ready = !(raw || waw || full).
  - dec_ready does not depend on dec_valid.
- BYPASS=1: for the hazard and full terms only, a same-cycle wb_valid to a pending register removes that register from P and decrements the count.
- BYPASS=0: a same-cycle writeback does not unblock; the stall lasts one extra cycle.
- Issue (accepted request):
  - Next cycle: iss_valid=1, iss_src_sel = src_imm ? 0 : rsrc_addr+1, iss_dst_idx = rdst_addr.
  - If wr_req, set P[rdst_addr].
  - Latency 1; back-to-back issue allowed every cycle.
  - Outputs hold their last values while iss_valid=0.
- Writeback:
  - wb_valid && P[wb_addr]: clear the bit; next cycle dst_we = 1<<wb_addr for exactly one cycle.
  - wb_valid && !P[wb_addr]: no dst_we, wb_err set sticky until reset.
- Simultaneous issue and writeback:
  - Set and clear to different registers both apply.
  - pend_cnt = pend_cnt + set − clear, never exceeding MAX_PEND and never below 0.
  - Set and clear to the same register cannot coexist: waw blocks the set unless BYPASS=1, in which case the clear is applied and the set wins, leaving the bit 1 and pend_cnt unchanged.
- dst_we is never multi-hot; iss_src_sel never exceeds NUM_REGS.

Decomposition:
- Shared package cpu_reg_pkg:
  - NUM_REGS default.
  - SRC_SEL_IMM = 0 constant.
  - onehot_dec and idx_to_sel functions.
- One sub-module: reg_scoreboard, covering the pending vector, pend_cnt, hazard/full logic and wb_err.
- Top level holds the issue registers and the dst_we register.

Test Plan:
- Reset, then issue rsrc=3, rdst=5, wr_req=1 → next cycle iss_valid=1, iss_src_sel=4, iss_dst_idx=5, pend_cnt=1.
- Issue with rsrc=5 while r5 is pending → dec_ready=0. wb_addr=5 (BYPASS=0) → the next cycle dst_we=16'h0020 and dec_ready=1, and the request issues the cycle after.
- src_imm=1, rsrc=15 → iss_src_sel=0 with no stall. Back-to-back issues on 4 consecutive cycles to r0..r3 → pend_cnt=4, and a 5th write is stalled (full) until one writeback.
- wb_addr=9 with r9 not pending → dst_we stays 0 and wb_err=1, persisting after later valid writebacks.
- BYPASS=1: r2 pending; issue rsrc=2 with wb_addr=2 in the same cycle → accepted that cycle, and dst_we=16'h0004 next cycle.
- Assert reset with 3 writes pending → pend_cnt=0 immediately. Later writebacks to those registers produce no dst_we and set wb_err. Also run NUM_REGS=8: rdst=7 writeback gives dst_we=8'h80.
